// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Requests are accepted only in IDLE; TX_OUT and busy are registered and change the cycle after the accepting edge.
module uart_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state_q, state_nxt;
  logic [PRESC_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic [IDX_W-1:0]        idx_q, idx_nxt;
  logic [DATA_WIDTH-1:0]   data_q, data_nxt;
  logic                    par_bit_q, par_bit_nxt;
  logic                    par_en_q, par_en_nxt;
  logic [PRESC_WIDTH-1:0]  presc_q, presc_nxt;
  logic                    tx_nxt;
  logic                    busy_nxt;
  logic [PRESC_WIDTH-1:0]  cnt_last_val;
  logic                    cnt_last;

  // Prescale values 0 and 1 both give a one-cycle bit period.
  assign cnt_last_val = (presc_q <= PRESC_WIDTH'(1)) ? '0 : presc_q - PRESC_WIDTH'(1);
  assign cnt_last     = (cnt_q == cnt_last_val);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      presc_q   <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      idx_q     <= idx_nxt;
      data_q    <= data_nxt;
      par_bit_q <= par_bit_nxt;
      par_en_q  <= par_en_nxt;
      presc_q   <= presc_nxt;
      TX_OUT    <= tx_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    idx_nxt     = idx_q;
    data_nxt    = data_q;
    par_bit_nxt = par_bit_q;
    par_en_nxt  = par_en_q;
    presc_nxt   = presc_q;

    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          data_nxt    = P_DATA;
          par_en_nxt  = PAR_EN;
          presc_nxt   = Prescale;
          par_bit_nxt = PAR_TYP ? ~^P_DATA : ^P_DATA;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt_q + PRESC_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          if (idx_q == LAST_IDX) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt_q + PRESC_WIDTH'(1);
        end
      end
      PARITY: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt_q + PRESC_WIDTH'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + PRESC_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the line level is registered with no input-to-output path.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_nxt[idx_nxt];
      PARITY:  tx_nxt = par_bit_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule
